// File: rtl/serial_addsub_seq.sv
// rtl/serial_addsub_seq.sv - bit-serial LSB-first sequencer for a 1-bit add/sub cell
// Optional signed-overflow output ovf is built when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             cell_a,
   output logic             cell_b,
   output logic             cell_cin,
   input  logic             cell_x,
   input  logic             cell_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CW-1:0]    cnt;
   logic             carry;

   // Cell inputs are only live while a bit is being processed.
   always_comb begin
      cell_a   = 1'b0;
      cell_b   = 1'b0;
      cell_cin = 1'b0;
      if (state == RUN) begin
         cell_a   = a_sh[0];
         cell_b   = b_sh[0];
         cell_cin = carry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh     <= op_a;
                  b_sh     <= op_b;
                  cnt      <= '0;
                  carry    <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               result <= {cell_x, result[WIDTH-1:1]};
               carry  <= cell_y;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB at this edge
                  cout      <= cell_y;
`ifdef SERIAL_ADDSUB_OVF_EN
                  ovf       <= carry ^ cell_y;
`endif
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb/tb_serial_addsub_seq.sv - scoreboard bench for serial_addsub_seq with a behavioural add/sub cell
// Checks ovf as well when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub_seq;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cell_a;
   logic         cell_b;
   logic         cell_cin;
   logic         cell_x;
   logic         cell_y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic         ovf;
`endif

   logic mode;
   int   checks;
   int   errors;
   int   cyc;
   int   acc_cyc;
   exp_t sb[$];

   serial_addsub_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cell_a    (cell_a),
      .cell_b    (cell_b),
      .cell_cin  (cell_cin),
      .cell_x    (cell_x),
      .cell_y    (cell_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
`ifdef SERIAL_ADDSUB_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // The cell: mode 0 adds, mode 1 subtracts (a - b - borrow_in).
   always_comb begin
      cell_x = cell_a ^ cell_b ^ cell_cin;
      if (!mode)
         cell_y = (cell_a & cell_b) | (cell_cin & (cell_a ^ cell_b));
      else
         cell_y = (~cell_a & cell_b) | (cell_cin & ~(cell_a ^ cell_b));
   end

   function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      exp_t       e;
      if (!m) s = {1'b0, a} + {1'b0, b};
      else    s = {1'b0, a} - {1'b0, b};
      e.res = s[W-1:0];
      e.c   = s[W];
      if (!m) e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      else    e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      op_a = a;
      op_b = b;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
      @(posedge clk);
      acc_cyc = cyc;
      sb.push_back(model(mode, a, b));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for out_valid, checks against the scoreboard, then consumes the result.
   task automatic recv(input bit chk_lat, input string tag);
      int   k;
      exp_t e;
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (chk_lat) chk({tag, "_latency"}, 64'(k), 64'(W));
      else if (k >= 100) chk({tag, "_timeout"}, 64'(k), 64'd0);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_result"}, 64'(result), 64'(e.res));
         chk({tag, "_cout"}, 64'(cout), 64'(e.c));
`ifdef SERIAL_ADDSUB_OVF_EN
         chk({tag, "_ovf"}, 64'(ovf), 64'(e.v));
`endif
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int   t0;
      bit   seen;
      logic [W-1:0] held;
      checks = 0;
      errors = 0;
      mode = 1'b0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op_a = '0;
      op_b = '0;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_cell", 64'({cell_a, cell_b, cell_cin}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Directed add cases
      send(8'h35, 8'h4A); recv(1, "add_35_4a");
      send(8'hFF, 8'h01); recv(1, "add_ff_01");
      send(8'h7F, 8'h01); recv(1, "add_7f_01");
      send(8'h00, 8'h00); recv(1, "add_00_00");

      // Directed subtract cases
      mode = 1'b1;
      send(8'h10, 8'h01); recv(1, "sub_10_01");
      send(8'h00, 8'h01); recv(1, "sub_00_01");
      send(8'h80, 8'h01); recv(1, "sub_80_01");

      // Backpressure with in_valid pulses during RUN and DONE
      mode = 1'b0;
      send(8'h12, 8'h34);
      op_a = 8'hAA;
      op_b = 8'h55;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_run_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      t0 = 0;
      while (!out_valid && t0 < 100) begin
         @(negedge clk);
         t0++;
      end
      held = result;
      chk("bp_result_first", 64'(held), 64'h46);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         op_a = 8'(i + 1);
         @(negedge clk);
         chk("bp_hold", 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, held}));
      end
      in_valid = 1'b0;
      recv(0, "bp");
      chk("bp_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
      seen = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("bp_no_capture", 64'(seen), 64'd0);

      // Asynchronous reset in the middle of RUN
      send(8'h35, 8'h4A);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_outputs", 64'({in_ready, out_valid, result, cout}), 64'd0);
      chk("midrst_cell", 64'({cell_a, cell_b, cell_cin}), 64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_stray", 64'(seen), 64'd0);
      send(8'h35, 8'h4A); recv(1, "after_rst");

      // Randomized back-to-back traffic with throughput measurement
      for (int m = 0; m < 2; m++) begin
         mode = m[0];
         t0 = 0;
         for (int i = 0; i < 1000; i++) begin
            send(W'($urandom), W'($urandom));
            if (i == 0) t0 = acc_cyc;
            recv(0, m == 0 ? "rnd_add" : "rnd_sub");
         end
         chk("throughput", 64'(acc_cyc - t0), 64'(999 * (W + 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
